// File: rtl/tt_timer_multi_pkg.sv
// Shared types and helpers for the multi-channel timer.
// Channel state, mode encodings and a clog2 helper.
package tt_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Index width for n items, never below one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tt_timer_multi_if.sv
// Config/control/status bundle of the multi-channel timer.
// master drives config and control, slave returns status.
interface tt_timer_multi_if
  import tt_timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int COUNT_W = 8,
  parameter int PRESC_W = 8,
  parameter int CH_W    = clog2(NUM_CH)
) ();

  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [COUNT_W-1:0] cfg_count;
  logic               cfg_periodic;
  logic [PRESC_W-1:0] prescale;
  logic [NUM_CH-1:0]  start;
  logic [NUM_CH-1:0]  stop;
  logic [NUM_CH-1:0]  clr_flag;
  logic [NUM_CH-1:0]  timer_reached;
  logic [NUM_CH-1:0]  timer_flag;
  logic [NUM_CH-1:0]  busy;

  modport master (
    output cfg_we, cfg_ch, cfg_count, cfg_periodic,
    output prescale, start, stop, clr_flag,
    input  timer_reached, timer_flag, busy
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_count, cfg_periodic,
    input  prescale, start, stop, clr_flag,
    output timer_reached, timer_flag, busy
  );

endinterface

// File: rtl/tt_timer_multi_channel.sv
// One countdown channel: reload/mode registers, FSM,
// counter, registered expiry pulse and sticky flag.
module tt_timer_channel
  import tt_timer_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_i,
  input  logic               we_i,
  input  logic [COUNT_W-1:0] count_i,
  input  logic               periodic_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               clr_i,
  output logic               reached_o,
  output logic               flag_o,
  output logic               busy_o
);

  logic [COUNT_W-1:0] reload_q;
  logic               mode_q;
  ch_state_e          state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               reached_q, reached_d;
  logic               flag_q, flag_d;
  logic               expire;

  // Config registers; a running count is untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
    end else if (we_i) begin
      reload_q <= count_i;
      mode_q   <= periodic_i;
    end
  end

  // Next state: stop > start > tick-driven countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    expire  = 1'b0;
    if (stop_i) begin
      state_d = ST_IDLE;
    end else if (start_i) begin
      if (reload_q != '0) begin
        cnt_d   = reload_q;
        state_d = ST_RUN;
      end else begin
        expire  = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_RUN && tick_i) begin
      if (cnt_q == COUNT_W'(1)) begin
        expire = 1'b1;
        if (mode_q == MODE_PERIODIC && reload_q != '0) begin
          cnt_d = reload_q;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        cnt_d = cnt_q - COUNT_W'(1);
      end
    end
    reached_d = expire;
    flag_d    = expire | (flag_q & ~clr_i);
  end

  // State, counter, pulse and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      reached_q <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reached_q <= reached_d;
      flag_q    <= flag_d;
    end
  end

  assign reached_o = reached_q;
  assign flag_o    = flag_q;
  assign busy_o    = (state_q == ST_RUN);

endmodule

// File: rtl/tt_timer_multi.sv
// Multi-channel countdown timer top: shared prescaler,
// config channel decode and NUM_CH channel instances.
module tt_timer_multi
  import tt_timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int COUNT_W = 8,
  parameter int PRESC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  tt_timer_multi_if.slave  bus
);

  logic [PRESC_W-1:0] psc_q, psc_d;
  logic               tick;
  logic [31:0]        ch_idx;
  logic [NUM_CH-1:0]  reached, flag, busy;

  // Prescaler wraps on tick or when prescale shrank below it.
  always_comb begin
    tick  = (psc_q == bus.prescale);
    psc_d = (psc_q >= bus.prescale) ? '0 : psc_q + PRESC_W'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) psc_q <= '0;
    else     psc_q <= psc_d;
  end

  assign ch_idx = 32'(bus.cfg_ch);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tt_timer_channel #(
      .COUNT_W (COUNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick_i     (tick),
      .we_i       (bus.cfg_we && (ch_idx == 32'(g))),
      .count_i    (bus.cfg_count),
      .periodic_i (bus.cfg_periodic),
      .start_i    (bus.start[g]),
      .stop_i     (bus.stop[g]),
      .clr_i      (bus.clr_flag[g]),
      .reached_o  (reached[g]),
      .flag_o     (flag[g]),
      .busy_o     (busy[g])
    );
  end

  assign bus.timer_reached = reached;
  assign bus.timer_flag    = flag;
  assign bus.busy          = busy;

endmodule

// File: tb/tb_tt_timer_multi.sv
// Bench for tt_timer_multi: per-cycle model compare
// plus directed latency/priority checks.
module tb_tt_timer_multi;
  import tt_timer_pkg::*;

  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int PW  = 8;
  localparam int CHW = clog2(NCH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_timer_multi_if #(
    .NUM_CH(NCH), .COUNT_W(CW), .PRESC_W(PW)
  ) bus ();

  tt_timer_multi #(
    .NUM_CH(NCH), .COUNT_W(CW), .PRESC_W(PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  int m_pc = 0;
  int m_rel [NCH];
  bit m_per [NCH];
  bit m_run [NCH];
  int m_left[NCH];
  logic [NCH-1:0] m_reached = '0;
  logic [NCH-1:0] m_flag = '0;
  logic [NCH-1:0] m_busy = '0;

  // Reference: ticks remaining until expiry per channel.
  always @(posedge clk) begin
    bit tk;
    bit ex;
    if (rst) begin
      m_pc = 0;
      for (int c = 0; c < NCH; c++) begin
        m_rel[c] = 0; m_per[c] = 0; m_run[c] = 0; m_left[c] = 0;
      end
      m_reached = '0; m_flag = '0; m_busy = '0;
    end else begin
      tk = (m_pc == int'(bus.prescale));
      m_pc = (m_pc >= int'(bus.prescale)) ? 0 : m_pc + 1;
      for (int c = 0; c < NCH; c++) begin
        ex = 0;
        if (bus.stop[c]) m_run[c] = 0;
        else if (bus.start[c]) begin
          if (m_rel[c] != 0) begin
            m_left[c] = m_rel[c]; m_run[c] = 1;
          end else begin
            ex = 1; m_run[c] = 0;
          end
        end else if (m_run[c] && tk) begin
          m_left[c] = m_left[c] - 1;
          if (m_left[c] == 0) begin
            ex = 1;
            if (m_per[c] && m_rel[c] != 0) m_left[c] = m_rel[c];
            else m_run[c] = 0;
          end
        end
        m_reached[c] = ex;
        m_flag[c] = ex | (m_flag[c] & ~bus.clr_flag[c]);
        m_busy[c] = m_run[c];
      end
      if (bus.cfg_we && int'(bus.cfg_ch) < NCH) begin
        m_rel[int'(bus.cfg_ch)] = int'(bus.cfg_count);
        m_per[int'(bus.cfg_ch)] = bus.cfg_periodic;
      end
    end
  end

  // Every-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (bus.timer_reached !== m_reached || bus.timer_flag !== m_flag ||
          bus.busy !== m_busy) begin
        fails++;
        $display("FAIL model t=%0t reached=%b exp=%b flag=%b exp=%b busy=%b exp=%b",
                 $time, bus.timer_reached, m_reached, bus.timer_flag, m_flag,
                 bus.busy, m_busy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic cfg(input int ch, input int cnt, input bit per);
    bus.cfg_we = 1'b1;
    bus.cfg_ch = CHW'(ch);
    bus.cfg_count = CW'(cnt);
    bus.cfg_periodic = per;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic go(input int ch);
    bus.start[ch] = 1'b1;
    step();
    bus.start[ch] = 1'b0;
  endtask

  task automatic wait_pulse(input int ch, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (bus.timer_reached[ch]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic quiet(input int ch, input int nc, output int seen);
    seen = 0;
    for (int i = 0; i < nc; i++) begin
      step();
      if (bus.timer_reached[ch]) seen++;
    end
  endtask

  int n, seen;

  initial begin
    rst = 1'b1;
    bus.cfg_we = 0; bus.cfg_ch = '0; bus.cfg_count = '0;
    bus.cfg_periodic = 0; bus.prescale = '0;
    bus.start = '0; bus.stop = '0; bus.clr_flag = '0;
    step();
    chk_en = 1;
    step();
    rst = 1'b0;
    chk("rst_reached", int'(bus.timer_reached), 0);
    chk("rst_flag", int'(bus.timer_flag), 0);
    chk("rst_busy", int'(bus.busy), 0);

    // one-shot latency
    cfg(0, 5, MODE_ONESHOT);
    go(0);
    chk("os_busy_on", int'(bus.busy[0]), 1);
    wait_pulse(0, 20, n);
    chk("os_latency", n, 5);
    chk("os_busy_off", int'(bus.busy[0]), 0);
    step(); step(); step();
    chk("os_pulse_1cyc", int'(bus.timer_reached[0]), 0);
    chk("os_flag_sticky", int'(bus.timer_flag[0]), 1);
    bus.clr_flag[0] = 1; step(); bus.clr_flag[0] = 0;
    chk("os_flag_clr", int'(bus.timer_flag[0]), 0);

    // periodic with prescale
    cfg(1, 3, MODE_PERIODIC);
    bus.prescale = PW'(2);
    go(1);
    wait_pulse(1, 40, n);
    chk("per_first", int'(n > 0), 1);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(1, 20, n);
      chk("per_period", n, 9);
    end
    bus.stop[1] = 1; step(); bus.stop[1] = 0;
    chk("per_stop_busy", int'(bus.busy[1]), 0);
    quiet(1, 30, seen);
    chk("per_stop_quiet", seen, 0);

    // zero reload and max reload
    bus.prescale = '0;
    cfg(2, 0, MODE_PERIODIC);
    go(2);
    chk("zero_pulse", int'(bus.timer_reached[2]), 1);
    chk("zero_busy", int'(bus.busy[2]), 0);
    step();
    chk("zero_single", int'(bus.timer_reached[2]), 0);
    cfg(3, 255, MODE_ONESHOT);
    go(3);
    wait_pulse(3, 300, n);
    chk("max_latency", n, 255);

    // start+stop together
    bus.start[0] = 1; bus.stop[0] = 1; step();
    bus.start[0] = 0; bus.stop[0] = 0;
    chk("ss_busy", int'(bus.busy[0]), 0);
    quiet(0, 10, seen);
    chk("ss_quiet", seen, 0);
    // restart at count 2
    go(0);
    step(); step(); step();
    go(0);
    wait_pulse(0, 20, n);
    chk("restart_full", n, 5);
    // clear in same cycle as expiry
    cfg(0, 2, MODE_ONESHOT);
    bus.clr_flag[0] = 1; step(); bus.clr_flag[0] = 0;
    chk("pre_clr", int'(bus.timer_flag[0]), 0);
    go(0);
    step();
    bus.clr_flag[0] = 1; step(); bus.clr_flag[0] = 0;
    chk("setclr_pulse", int'(bus.timer_reached[0]), 1);
    chk("setclr_flag", int'(bus.timer_flag[0]), 1);

    // reconfigure running periodic channel 4 -> 6
    cfg(1, 4, MODE_PERIODIC);
    go(1);
    step();
    cfg(1, 6, MODE_PERIODIC);
    wait_pulse(1, 20, n);
    chk("recfg_cur", n, 2);
    wait_pulse(1, 20, n);
    chk("recfg_next", n, 6);
    bus.stop[1] = 1; step(); bus.stop[1] = 0;
    // out-of-range config index
    cfg(4, 3, MODE_ONESHOT);
    cfg(7, 9, MODE_PERIODIC);
    go(4);
    wait_pulse(4, 20, n);
    chk("oor_ignored", n, 3);

    // reset mid-count
    cfg(0, 7, MODE_PERIODIC);
    bus.start = 5'b01011; step(); bus.start = '0;
    step(); step(); step();
    rst = 1; step(); rst = 0;
    chk("mrst_reached", int'(bus.timer_reached), 0);
    chk("mrst_flag", int'(bus.timer_flag), 0);
    chk("mrst_busy", int'(bus.busy), 0);
    quiet(0, 5, seen);
    chk("mrst_idle", int'(bus.busy) + seen, 0);
    go(0);
    chk("mrst_zero_pulse", int'(bus.timer_reached[0]), 1);
    chk("mrst_zero_busy", int'(bus.busy[0]), 0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
